pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000: the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state updates on posedge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port branch, input, 1: registered taken-branch flag from the branch unit.
REQ-005 The block SHALL have port offset, input, 32: registered, sign-extended, pre-shifted branch byte offset.
REQ-006 The block SHALL have port jump, input, 1: registered jump flag from the branch unit.
REQ-007 The block SHALL have port target, input, 32: registered absolute jump address.
REQ-008 The block SHALL have port stall, input, 1: downstream is not accepting; hold the presented instruction.
REQ-009 The block SHALL have port imem_req, output, 1: instruction memory request.
REQ-010 The block SHALL have port imem_addr, output, 32: request address.
REQ-011 The block SHALL have port imem_ack, input, 1: memory response valid.
REQ-012 The block SHALL have port imem_rdata, input, 32: response word.
REQ-013 The block SHALL have port instr, output, 32: fetched instruction.
REQ-014 The block SHALL have port instr_pc, output, 32: address of instr.
REQ-015 The block SHALL have port instr_valid, output, 1: instr/instr_pc are valid.
REQ-016 The block SHALL have port pc_h4, output, 4: instr_pc[31:28], fed to the branch unit for jump target formation.
REQ-017 The block SHALL have port misalign, output, 1: sticky misaligned-redirect flag.

Function
REQ-018 The block SHALL implement FSM states: IDLE (1 cycle after reset release, no request), FETCH (imem_req=1, waiting for imem_ack), HOLD (instr_valid=1, stall=1).
REQ-019 Transitions SHALL be: IDLE->FETCH always; FETCH->FETCH on ack with stall=0 (back-to-back, next address issued the following cycle); FETCH->HOLD on ack with stall=1; HOLD->FETCH when stall=0.
REQ-020 Latency SHALL be: request issued the cycle after entering FETCH; instr_valid asserted the cycle after imem_ack; one fetch per ack, no overlapping requests.
REQ-021 imem_addr SHALL be held stable while imem_req=1 and imem_ack=0.
REQ-022 Sequential next PC SHALL be instr_pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-023 A redirect SHALL be sampled every cycle: jump -> target; branch -> instr_pc+4+offset (32-bit wrap); jump and branch in the same cycle -> jump wins.
REQ-024 A redirect during FETCH SHALL NOT cancel the outstanding request; the block SHALL set a kill flag, discard that response (instr_valid stays 0), then fetch the redirect address.
REQ-025 A redirect in HOLD or when no request is outstanding SHALL deassert instr_valid next cycle and fetch the redirect address next.
REQ-026 Only the newest redirect SHALL be retained if a second arrives before the first is fetched.
REQ-027 stall SHALL freeze instr, instr_pc and instr_valid; redirects are still captured during stall.
REQ-028 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-029 On reset=0, the block SHALL immediately enter IDLE with imem_req=0, instr_valid=0, instr=0, instr_pc=RESET_PC-4, misalign=0, kill and pending redirect cleared.
REQ-030 After reset release, the first imem_addr SHALL be RESET_PC; reset asserted mid-fetch SHALL drop imem_req asynchronously, and a late ack SHALL be ignored.

Configuration
REQ-031 With macro PC_ALIGN_CHECK_EN defined, a redirect address with [1:0]!=0 SHALL set misalign (sticky until reset) and be ignored, so sequential fetch continues; without it, address bits [1:0] SHALL be forced to 00 and misalign tied to 0.

Structure
REQ-032 Package pc_fetch_pkg SHALL hold the FSM state typedef, PC_INC=4 and the RESET_PC default.
REQ-033 Next-PC selection (sequential/branch/jump, priority, alignment handling) SHALL be sub-module pc_next_sel, purely combinational.

Verification
REQ-034 The bench SHALL cover: reset release, ack every cycle -> imem_addr 0x3000, 0x3004, 0x3008; instr_pc follows one cycle after each ack.
REQ-035 The bench SHALL cover: branch=1, offset=0x10, instr_pc=0x3004 -> next fetch 0x3018; jump=1, target=0x0040_0000 on the same cycle -> fetch 0x0040_0000.
REQ-036 The bench SHALL cover: redirect while ack pending 3 cycles -> that response is discarded (instr_valid=0), then fetch the target.
REQ-037 The bench SHALL cover: stall=1 for 4 cycles after ack -> instr/instr_pc held, no imem_req; on release, fetch instr_pc+4.
REQ-038 The bench SHALL cover: instr_pc=0xFFFF_FFFC -> next fetch 0x0000_0000.
REQ-039 The bench SHALL cover: with PC_ALIGN_CHECK_EN, jump target 0x0000_3002 -> misalign=1 and fetch continues sequentially; without the macro -> fetch 0x0000_3000.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC/fetch unit.
// Optional misaligned-redirect checking is selected by PC_ALIGN_CHECK_EN.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } fetch_state_e;

  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

endpackage

// File: rtl/pc_next_sel.sv
// Redirect/sequential next-PC selection; jump beats branch.
// PC_ALIGN_CHECK_EN: misaligned redirects are flagged and dropped.
module pc_next_sel
  import pc_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic [31:0] offset,
  input  logic        jump,
  input  logic [31:0] target,
  output logic        redir,
  output logic [31:0] redir_pc,
  output logic [31:0] seq_pc,
  output logic        mis
);

  logic [31:0] raw;
  logic        any;

  always_comb begin
    seq_pc = pc + PC_INC;
    any    = jump | branch;
    raw    = jump ? target : seq_pc + offset;
`ifdef PC_ALIGN_CHECK_EN
    mis      = any && (raw[1:0] != 2'b00);
    redir    = any && (raw[1:0] == 2'b00);
    redir_pc = raw;
`else
    mis      = 1'b0;
    redir    = any;
    redir_pc = raw & ~32'h3;
`endif
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch.
// PC_ALIGN_CHECK_EN enables the sticky misalign flag.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch,
  input  logic [31:0] offset,
  input  logic        jump,
  input  logic [31:0] target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [3:0]  pc_h4,
  output logic        misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         kill_q, kill_d;
  logic [31:0]  rp_q, rp_d;
  logic         mis_q, mis_d;

  logic         redir;
  logic [31:0]  redir_pc;
  logic [31:0]  seq_pc;
  logic         mis_evt;

  pc_next_sel u_sel (
    .pc       (pc_q),
    .branch   (branch),
    .offset   (offset),
    .jump     (jump),
    .target   (target),
    .redir    (redir),
    .redir_pc (redir_pc),
    .seq_pc   (seq_pc),
    .mis      (mis_evt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC - PC_INC;
      instr_q <= '0;
      valid_q <= 1'b0;
      kill_q  <= 1'b0;
      rp_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      kill_q  <= kill_d;
      rp_q    <= rp_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    kill_d  = kill_q;
    rp_d    = rp_q;
    mis_d   = mis_q | mis_evt;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        addr_d  = redir ? redir_pc : seq_pc;
      end
      FETCH: begin
        if (imem_ack) begin
          // a redirect seen with or before the ack makes it wrong-path
          if (kill_q || redir) begin
            valid_d = 1'b0;
            kill_d  = 1'b0;
            addr_d  = redir ? redir_pc : rp_q;
          end else begin
            pc_d    = addr_q;
            instr_d = imem_rdata;
            valid_d = 1'b1;
            if (stall) state_d = HOLD;
            else       addr_d  = addr_q + PC_INC;
          end
        end else if (redir) begin
          kill_d  = 1'b1;
          rp_d    = redir_pc;
          valid_d = 1'b0;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redir) begin
          valid_d = 1'b0;
          state_d = FETCH;
          addr_d  = redir_pc;
        end else if (!stall) begin
          valid_d = 1'b0;
          state_d = FETCH;
          addr_d  = seq_pc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_pc    = pc_q;
  assign instr_valid = valid_q;
  assign pc_h4       = pc_q[31:28];
  assign misalign    = mis_q;

endmodule
